// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: byte-enable encodings, default sizes
// and the legal byte-enable check used by the acceptance assertion.
package store_buffer_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 12;

  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;
  localparam logic [3:0] BE_H0 = 4'b0011;
  localparam logic [3:0] BE_H1 = 4'b1100;
  localparam logic [3:0] BE_W  = 4'b1111;

  function automatic logic is_legal_be(input logic [3:0] be);
    return (be == BE_B0) || (be == BE_B1) || (be == BE_B2) || (be == BE_B3) ||
           (be == BE_H0) || (be == BE_H1) || (be == BE_W);
  endfunction

endpackage

// File: rtl/store_buffer_sb_queue.sv
// Circular store queue: push at tail, pop at head, one of each per cycle; state updates at the edge.
// Also reports which live entries hold a given word address (for load conflict detection).
module sb_queue
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [AW-1:0]            push_addr,
  input  logic [31:0]              push_data,
  input  logic [3:0]               push_be,
  input  logic                     pop,
  input  logic [AW-1:0]            match_addr,
  output logic [AW-1:0]            head_addr,
  output logic [31:0]              head_data,
  output logic [3:0]               head_be,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DEPTH-1:0]         match_vec
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;

  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [3:0]    be_q   [DEPTH];
  logic [3:0]    be_d   [DEPTH];

  logic [PW-1:0] offset;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    if (push) begin
      addr_d[tail_q] = push_addr;
      data_d[tail_q] = push_data;
      be_d[tail_q]   = push_be;
      tail_d         = tail_q + 1'b1;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
    end
    count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
  end

  // An entry is live when its distance from head is below count.
  always_comb begin
    offset    = '0;
    match_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset       = PW'(i) - head_q;
      match_vec[i] = ({1'b0, offset} < count_q) && (addr_q[i] == match_addr);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    be_q   <= be_d;
  end

  assign head_addr = addr_q[head_q];
  assign head_data = data_q[head_q];
  assign head_be   = be_q[head_q];
  assign count     = count_q;

endmodule

// File: rtl/store_buffer.sv
// Store queue plus single-port dm arbiter: stores drain in order one per cycle, at least one edge after accept.
// St_ready drops only when full; loads get the port combinationally unless they hit a buffered/incoming store or the queue is full.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          St_valid,
  input  logic [AW-1:0] St_addr,
  input  logic [31:0]   St_data,
  input  logic [3:0]    St_be,
  output logic          St_ready,
  input  logic          Ld_valid,
  input  logic [AW-1:0] Ld_addr,
  output logic          Ld_ready,
  output logic          Sb_empty,
  output logic [AW-1:0] Dm_addr,
  output logic [31:0]   Dm_din,
  output logic [3:0]    Dm_be,
  output logic          Dm_we
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [AW-1:0]    head_addr;
  logic [31:0]      head_data;
  logic [3:0]       head_be;
  logic [PW:0]      count;
  logic [DEPTH-1:0] match_vec;
  logic             full;
  logic             conflict;
  logic             drain;
  logic             ld_grant;
  logic             push;

  sb_queue #(.DEPTH(DEPTH), .AW(AW)) u_queue (
    .clk        (Clk),
    .rst_n      (Reset),
    .push       (push),
    .push_addr  (St_addr),
    .push_data  (St_data),
    .push_be    (St_be),
    .pop        (drain),
    .match_addr (Ld_addr),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .head_be    (head_be),
    .count      (count),
    .match_vec  (match_vec)
  );

  assign full     = (count == FULL_CNT);
  assign St_ready = Reset && !full;
  assign push     = St_valid && St_ready;
  assign Sb_empty = (count == '0);

  // The incoming-store term is conservative: it stalls even if that store is not accepted.
  assign conflict = Ld_valid && ((|match_vec) || (St_valid && (St_addr == Ld_addr)));

  always_comb begin
    drain    = 1'b0;
    ld_grant = 1'b0;
    if (Reset) begin
      if (full && (count != '0)) begin
        drain = 1'b1;
      end else if (Ld_valid && !conflict) begin
        ld_grant = 1'b1;
      end else if (count != '0) begin
        drain = 1'b1;
      end
    end
  end

  always_comb begin
    Dm_we    = drain;
    Ld_ready = ld_grant;
    Dm_addr  = drain ? head_addr : Ld_addr;
    Dm_din   = drain ? head_data : 32'h0;
    Dm_be    = drain ? head_be   : 4'h0;
  end

  a_legal_be: assert property (@(posedge Clk) (Reset && St_valid && St_ready) |-> is_legal_be(St_be));

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a queue-based reference model predicts each cycle's port outputs.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data;
  logic [3:0]    st_be;
  logic          st_ready;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic          ld_ready;
  logic          sb_empty;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_din;
  logic [3:0]    dm_be;
  logic          dm_we;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .Clk      (clk),
    .Reset    (rst_n),
    .St_valid (st_valid),
    .St_addr  (st_addr),
    .St_data  (st_data),
    .St_be    (st_be),
    .St_ready (st_ready),
    .Ld_valid (ld_valid),
    .Ld_addr  (ld_addr),
    .Ld_ready (ld_ready),
    .Sb_empty (sb_empty),
    .Dm_addr  (dm_addr),
    .Dm_din   (dm_din),
    .Dm_be    (dm_be),
    .Dm_we    (dm_we)
  );

  typedef struct {
    logic          ld_ready;
    logic          we;
    logic          st_ready;
    logic          empty;
    logic [AW-1:0] addr;
    logic [31:0]   din;
    logic [3:0]    be;
  } exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    be;
  } st_t;

  exp_t  chk_q[$];
  st_t   sbq[$];
  logic [31:0] ref_mem [1 << AW];
  logic [31:0] dut_mem [1 << AW];
  logic [3:0]  be_tab [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Reference model: predicts this cycle's outputs from the buffered-store queue, then applies the edge.
  task automatic model_step();
    exp_t e;
    st_t  h;
    logic conflict;
    logic drain;
    int   cnt;
    cnt = sbq.size();
    conflict = ld_valid && (st_valid && st_addr == ld_addr);
    foreach (sbq[i]) if (ld_valid && sbq[i].addr == ld_addr) conflict = 1'b1;
    e.ld_ready = 1'b0;
    e.st_ready = rst_n && (cnt < DEPTH);
    e.empty    = (cnt == 0);
    e.addr     = ld_addr;
    e.din      = 32'h0;
    e.be       = 4'h0;
    drain = 1'b0;
    if (rst_n) begin
      if (cnt == DEPTH)                drain = 1'b1;
      else if (ld_valid && !conflict)  e.ld_ready = 1'b1;
      else if (cnt != 0)               drain = 1'b1;
    end
    e.we = drain;
    if (drain) begin
      h = sbq.pop_front();
      e.addr = h.addr;
      e.din  = h.data;
      e.be   = h.be;
      ref_mem[h.addr] = merge(ref_mem[h.addr], h.data, h.be);
    end
    if (!rst_n) sbq.delete();
    else if (st_valid && e.st_ready) sbq.push_back('{st_addr, st_data, st_be});
    chk_q.push_back(e);
  endtask

  task automatic cycle(input logic rst, input logic stv, input logic [AW-1:0] sta,
                       input logic [31:0] std, input logic [3:0] stb,
                       input logic ldv, input logic [AW-1:0] lda);
    @(posedge clk);
    #1;
    rst_n = rst; st_valid = stv; st_addr = sta; st_data = std; st_be = stb;
    ld_valid = ldv; ld_addr = lda;
    model_step();
  endtask

  // Monitor: compares DUT outputs against the predicted cycle, and mirrors dm writes into a memory image.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_q.size() > 0) begin
        e = chk_q.pop_front();
        check("ld_ready", {31'b0, ld_ready}, {31'b0, e.ld_ready});
        check("dm_we",    {31'b0, dm_we},    {31'b0, e.we});
        check("st_ready", {31'b0, st_ready}, {31'b0, e.st_ready});
        check("sb_empty", {31'b0, sb_empty}, {31'b0, e.empty});
        check("dm_addr",  {20'b0, dm_addr},  {20'b0, e.addr});
        check("dm_din",   dm_din,            e.din);
        check("dm_be",    {28'b0, dm_be},    {28'b0, e.be});
        if (dm_we) dut_mem[dm_addr] = merge(dut_mem[dm_addr], dm_din, dm_be);
      end
    end
  end

  initial begin
    int bad;
    for (int a = 0; a < (1 << AW); a++) begin
      ref_mem[a] = 32'h0;
      dut_mem[a] = 32'h0;
    end
    rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = 4'hF;
    ld_valid = 1'b0; ld_addr = '0;

    // Reset held with a store presented, then release.
    cycle(0, 1, 12'h005, 32'h1111_1111, 4'hF, 0, 0);
    cycle(0, 1, 12'h005, 32'h1111_1111, 4'hF, 0, 0);
    cycle(1, 0, 0, 0, 4'hF, 0, 0);

    // Single store then drain.
    cycle(1, 1, 12'h010, 32'hDEAD_BEEF, 4'b1111, 0, 0);
    cycle(1, 0, 0, 0, 4'hF, 0, 0);
    cycle(1, 0, 0, 0, 4'hF, 0, 0);

    // Fill under load pressure, then forced drain while full.
    for (int i = 1; i <= 4; i++) cycle(1, 1, AW'(i), 32'hA000_0000 + i, 4'hF, 1, 12'h100);
    cycle(1, 0, 0, 0, 4'hF, 1, 12'h100);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 4'hF, 0, 0);

    // Read-after-write conflict on a buffered byte store.
    cycle(1, 1, 12'h020, 32'h0000_00AB, 4'b0001, 0, 0);
    cycle(1, 0, 0, 0, 4'hF, 1, 12'h020);
    cycle(1, 0, 0, 0, 4'hF, 1, 12'h020);

    // Wrap-around with partial load pressure.
    for (int i = 0; i < 7; i++) cycle(1, 1, 12'h030 + AW'(i), i, 4'hF, (i % 2 == 0), 12'h200);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 4'hF, 0, 0);

    // Reset with three stores still buffered: they must never reach dm.
    for (int i = 0; i < 3; i++) cycle(1, 1, 12'h040 + AW'(i), 32'h5555_0000 + i, 4'hF, 1, 12'h300);
    cycle(0, 0, 0, 0, 4'hF, 0, 0);
    cycle(1, 0, 0, 0, 4'hF, 0, 0);
    cycle(1, 0, 0, 0, 4'hF, 0, 0);

    // Randomized traffic on a small address window to provoke conflicts.
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 199) != 0),
            ($urandom_range(0, 99) < 60), AW'($urandom_range(0, 15)), $urandom,
            be_tab[$urandom_range(0, 6)],
            ($urandom_range(0, 99) < 50), AW'($urandom_range(0, 15)));
    end
    for (int i = 0; i < DEPTH + 2; i++) cycle(1, 0, 0, 0, 4'hF, 0, 0);

    for (int i = 0; i < 20 && chk_q.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", chk_q.size(), 0);

    bad = 0;
    for (int a = 0; a < (1 << AW); a++) if (dut_mem[a] !== ref_mem[a]) bad++;
    check("dm_image_mismatches", bad, 0);
    check("dm_040_after_reset", dut_mem[12'h040], 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- M-stage store queue and single-port arbiter sitting directly upstream of the data memory.
- Accepts word-aligned stores (address, data, byte enables) from the M stage and drains them to the dm port in program order, one per cycle.
- Lets loads use the dm port combinationally when no buffered store conflicts; raises a load stall on an address match so the pipeline never reads stale data.

Parameters:
- DEPTH, 4, number of store entries (power of two, >=2)
- AW, 12, word-address width (address bits [13:2])

Ports:
- Clk  in  1  clock, all state on rising edge
- Reset  in  1  synchronous, active-low reset
- St_valid  in  1  M stage presents a store this cycle
- St_addr  in  AW  store word address
- St_data  in  32  store data, already lane-aligned
- St_be  in  4  byte enables; legal values only: 0001, 0010, 0100, 1000, 0011, 1100, 1111
- St_ready  out  1  store accepted at this edge when St_valid&St_ready
- Ld_valid  in  1  M stage presents a load this cycle
- Ld_addr  in  AW  load word address
- Ld_ready  out  1  load owns dm port this cycle; dm read data valid combinationally
- Sb_empty  out  1  no buffered stores (used by fence/syscall logic)
- Dm_addr  out  AW  to dm Addr
- Dm_din  out  32  to dm Din
- Dm_be  out  4  to dm Be
- Dm_we  out  1  to dm We

Behaviour:
- Storage: circular FIFO of DEPTH entries {addr, data, be}, head/tail pointers of log2(DEPTH) bits, count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Reset (Reset==0 at edge):
  - count, head and tail go to 0; contents are discarded.
  - During a Reset-low cycle: Dm_we=0, Ld_ready=0, St_ready=0.
  - After reset: St_ready=1, Sb_empty=1, Dm_we=0.
- St_ready = (count != DEPTH). No push-through when full. A store is pushed at tail when St_valid&St_ready.
- Latency: an accepted store reaches dm at the next edge at the earliest. It is never written in its accept cycle.
- Conflict: conflict = Ld_valid & (any valid entry addr == Ld_addr, or St_valid & St_addr == Ld_addr). The incoming-store check is conservative.
- Port arbitration, per cycle, combinational, evaluated in this order:
  1. count==DEPTH & count!=0: drain. Dm_we=1, Ld_ready=0.
  2. Ld_valid & !conflict: load. Dm_addr=Ld_addr, Dm_we=0, Ld_ready=1.
  3. count!=0: drain. Dm_we=1, Dm_addr/Dm_din/Dm_be = head entry, Ld_ready=0.
  4. Otherwise idle. Dm_we=0, Dm_addr=Ld_addr, Ld_ready=0.
- Drain pops the head at the same edge dm writes it.
- Simultaneous push and pop: count is unchanged, both pointers advance. Full with a drain: St_ready stays 0 that cycle; the freed slot is visible next cycle.
- Ordering: dm write order equals store accept order, always. Same-address stores are not coalesced.
- Dm_din and Dm_be are 0 whenever Dm_we=0.
- Sb_empty = (count==0), combinational from registered count.
- Illegal St_be: assertion fires in simulation; the entry is still queued unchanged.

Decomposition:
- Shared header: BE encodings (BE_B0..BE_B3, BE_H0, BE_H1, BE_W), AW default, and an is_legal_be check macro.
- One sub-module, sb_queue: entry storage, pointers, count, push/pop, and a per-entry address-match vector output.
- store_buffer top: conflict reduction, arbitration priority, dm port muxing.

Test Plan:
- Reset: hold Reset=0 for 2 cycles with St_valid=1 → St_ready=0, Dm_we=0. Release → St_ready=1, Sb_empty=1, Dm_we=0.
- Single store: addr 0x010, data 0xDEADBEEF, be 1111, no loads → next cycle Dm_we=1, Dm_addr=0x010, Dm_din=0xDEADBEEF, Dm_be=1111. Cycle after: Sb_empty=1, Dm_we=0.
- Fill under load pressure: 4 stores to 0x001..0x004 while Ld_valid=1, Ld_addr=0x100 → Ld_ready=1 and Dm_we=0 until count=4. Then St_ready=0, Ld_ready=0, Dm_we=1, Dm_addr=0x001.
- RAW conflict: store 0x020, be 0001, data 0x000000AB, then load 0x020 next cycle → Ld_ready=0 while the entry is buffered. The drain cycle writes 0x020. Next cycle Ld_ready=1, Dm_addr=0x020, Dm_we=0.
- Wrap-around: 7 stores (addr 0x030+i, data i) with drains interleaved, pointers crossing DEPTH twice → dm writes observed in order i=0..6. Data matches; count never exceeds 4.
- Reset mid-operation: 3 entries buffered, Reset=0 for one cycle → no further Dm_we. Sb_empty=1 and St_ready=1 after release. dm contents at those addresses are unchanged.
